// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the core's I/D requesters, the arbiter and the unified memory.
// master: core requesters plus memory model; slave: the arbiter.
interface mem_port_arbiter_if;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_gnt;
    logic        i_rvalid;
    logic [31:0] i_rdata;

    logic        d_req;
    logic        d_rd_wr;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;

    logic        mem_en;
    logic        mem_rd_wr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport master (
        output i_req, i_addr, d_req, d_rd_wr, d_addr, d_wdata, mem_rdata,
        input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
        input  mem_en, mem_rd_wr, mem_addr, mem_wdata
    );

    modport slave (
        input  i_req, i_addr, d_req, d_rd_wr, d_addr, d_wdata, mem_rdata,
        output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
        output mem_en, mem_rd_wr, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates one fixed-latency memory port between instruction fetch (I) and
// data access (D). D wins by default; after MAX_DATA_STREAK back-to-back D grants
// with I waiting, I is forced through once. Read grants are tagged so responses
// return to the requester that issued them.
module mem_port_arbiter #(
    parameter int unsigned MEM_LATENCY     = 1,
    parameter int unsigned MAX_DATA_STREAK = 4
) (
    input logic                clk,
    input logic                reset,
    mem_port_arbiter_if.slave  bus
);

    typedef enum logic {
        NORMAL,
        FORCE_I
    } state_t;

    localparam logic [3:0] MAX_STREAK = 4'(MAX_DATA_STREAK);

    state_t                  r_state;
    state_t                  w_state_next;
    logic [3:0]              r_streak;
    logic [3:0]              w_streak_next;
    logic [3:0]              w_streak_inc;
    logic                    w_i_gnt;
    logic                    w_d_gnt;
    logic                    w_rd_issue;
    logic [MEM_LATENCY-1:0]  r_tag_valid;
    logic [MEM_LATENCY-1:0]  r_tag_src;
    logic                    w_out_valid;

    // Grant selection and memory command drive; nothing is granted while in reset
    always_comb begin
        w_i_gnt = 1'b0;
        w_d_gnt = 1'b0;
        if (!reset) begin
            case (r_state)
                NORMAL: begin
                    if (bus.d_req)      w_d_gnt = 1'b1;
                    else if (bus.i_req) w_i_gnt = 1'b1;
                end
                FORCE_I: begin
                    if (bus.i_req)      w_i_gnt = 1'b1;
                    else if (bus.d_req) w_d_gnt = 1'b1;
                end
                default: ;
            endcase
        end

        bus.i_gnt     = w_i_gnt;
        bus.d_gnt     = w_d_gnt;
        bus.mem_en    = 1'b0;
        bus.mem_rd_wr = 1'b1;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        if (w_i_gnt) begin
            bus.mem_en   = 1'b1;
            bus.mem_addr = bus.i_addr;
        end else if (w_d_gnt) begin
            bus.mem_en    = 1'b1;
            bus.mem_rd_wr = bus.d_rd_wr;
            bus.mem_addr  = bus.d_addr;
            bus.mem_wdata = bus.d_wdata;
        end
    end

    // Streak tracking and fairness state transitions
    always_comb begin
        w_streak_inc  = r_streak + 4'd1;
        w_streak_next = r_streak;
        w_state_next  = r_state;

        if (!bus.i_req || w_i_gnt) begin
            w_streak_next = '0;
        end else if (w_d_gnt) begin
            w_streak_next = w_streak_inc;
        end

        case (r_state)
            NORMAL: begin
                if (w_d_gnt && bus.i_req && (w_streak_inc == MAX_STREAK))
                    w_state_next = FORCE_I;
            end
            FORCE_I: begin
                if (w_i_gnt || !bus.i_req)
                    w_state_next = NORMAL;
            end
            default: w_state_next = NORMAL;
        endcase
    end

    // FSM and streak registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= NORMAL;
            r_streak <= '0;
        end else begin
            r_state  <= w_state_next;
            r_streak <= w_streak_next;
        end
    end

    assign w_rd_issue = w_i_gnt || (w_d_gnt && bus.d_rd_wr);

    // Tag pipeline tracking which requester owns each in-flight read
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tag_valid <= '0;
            r_tag_src   <= '0;
        end else begin
            r_tag_valid[0] <= w_rd_issue;
            r_tag_src[0]   <= w_d_gnt;
            for (int unsigned k = 1; k < MEM_LATENCY; k++) begin
                r_tag_valid[k] <= r_tag_valid[k-1];
                r_tag_src[k]   <= r_tag_src[k-1];
            end
        end
    end

    // Route the emerging read data to its owner; zero data when not valid
    always_comb begin
        w_out_valid  = r_tag_valid[MEM_LATENCY-1] && !reset;
        bus.i_rvalid = w_out_valid && !r_tag_src[MEM_LATENCY-1];
        bus.d_rvalid = w_out_valid &&  r_tag_src[MEM_LATENCY-1];
        bus.i_rdata  = bus.i_rvalid ? bus.mem_rdata : '0;
        bus.d_rdata  = bus.d_rvalid ? bus.mem_rdata : '0;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: two instances (MEM_LATENCY 2 and 3)
// share the same directed stimulus; each has its own memory model.
module tb_mem_port_arbiter;

    localparam logic [1:0] NONE = 2'd0;
    localparam logic [1:0] GI   = 2'd1;
    localparam logic [1:0] GD   = 2'd2;

    typedef struct {
        int          cyc;
        logic [1:0]  g;
        logic [31:0] addr;
        logic        rw;
        logic [31:0] wd;
    } gexp_t;

    typedef struct {
        int          due;
        logic        src;
        logic [31:0] data;
    } rexp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic        d_req = 1'b0;
    logic        d_rd_wr = 1'b1;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    logic done = 1'b0;
    logic fin  = 1'b0;

    gexp_t gq [$];
    rexp_t rq [2][$];

    logic [1:0]  o_ig, o_dg, o_en, o_rw, o_iv, o_dv;
    logic [31:0] o_ma [2];
    logic [31:0] o_mw [2];
    logic [31:0] o_ir [2];
    logic [31:0] o_dr [2];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] memf(input logic [31:0] a);
        if (a == 32'h0000_0100) return 32'h2402_0005;
        return a + 32'h1111_0000;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int unsigned LAT = g + 2;
        logic [31:0] r_pa [LAT];
        logic        r_pv [LAT];

        mem_port_arbiter_if bus ();

        mem_port_arbiter #(
            .MEM_LATENCY     (LAT),
            .MAX_DATA_STREAK (4)
        ) u_dut (
            .clk   (clk),
            .reset (reset),
            .bus   (bus)
        );

        assign bus.i_req   = i_req;
        assign bus.i_addr  = i_addr;
        assign bus.d_req   = d_req;
        assign bus.d_rd_wr = d_rd_wr;
        assign bus.d_addr  = d_addr;
        assign bus.d_wdata = d_wdata;

        always @(posedge clk) begin
            r_pv[0] <= bus.mem_en && bus.mem_rd_wr;
            r_pa[0] <= bus.mem_addr;
            for (int k = 1; k < int'(LAT); k++) begin
                r_pv[k] <= r_pv[k-1];
                r_pa[k] <= r_pa[k-1];
            end
        end

        assign bus.mem_rdata = r_pv[LAT-1] ? memf(r_pa[LAT-1]) : 32'hBAD0_BAD0;

        assign o_ig[g] = bus.i_gnt;
        assign o_dg[g] = bus.d_gnt;
        assign o_en[g] = bus.mem_en;
        assign o_rw[g] = bus.mem_rd_wr;
        assign o_iv[g] = bus.i_rvalid;
        assign o_dv[g] = bus.d_rvalid;
        assign o_ma[g] = bus.mem_addr;
        assign o_mw[g] = bus.mem_wdata;
        assign o_ir[g] = bus.i_rdata;
        assign o_dr[g] = bus.d_rdata;
    end

    // One cycle of stimulus plus its hand-computed expectations
    task automatic step(input logic rst, input logic ir, input logic [31:0] ia,
                        input logic dr, input logic drw, input logic [31:0] da,
                        input logic [31:0] dwd, input logic [1:0] eg,
                        input logic [31:0] edata);
        gexp_t ge;
        rexp_t re;
        @(posedge clk);
        #1;
        reset   = rst;
        i_req   = ir;
        i_addr  = ia;
        d_req   = dr;
        d_rd_wr = drw;
        d_addr  = da;
        d_wdata = dwd;
        ge.cyc  = cyc;
        ge.g    = eg;
        ge.addr = 32'h0;
        ge.rw   = 1'b1;
        ge.wd   = 32'h0;
        if (eg == GI) begin
            ge.addr = ia;
        end else if (eg == GD) begin
            ge.addr = da;
            ge.rw   = drw;
            ge.wd   = dwd;
        end
        gq.push_back(ge);
        if (eg == GI || (eg == GD && drw)) begin
            for (int k = 0; k < 2; k++) begin
                re.due  = cyc + k + 2;
                re.src  = (eg == GD);
                re.data = edata;
                rq[k].push_back(re);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) step(0, 0, 0, 0, 1, 0, 0, NONE, 0);
    endtask

    gexp_t       mge;
    rexp_t       mre;
    logic [67:0] ga, gx;
    logic [31:0] got_d;

    // Monitor: compares grants and responses against the queued expectations
    always @(negedge clk) begin
        if (gq.size() != 0 && gq[0].cyc == cyc) begin
            mge = gq.pop_front();
            gx = {mge.g == GI, mge.g == GD, mge.g != NONE, mge.rw, mge.addr, mge.wd};
            for (int k = 0; k < 2; k++) begin
                ga = {o_ig[k], o_dg[k], o_en[k], o_rw[k], o_ma[k], o_mw[k]};
                checks++;
                if (ga !== gx) begin
                    errors++;
                    $display("FAIL grant lat=%0d cyc=%0d got=%h exp=%h", k + 2, cyc, ga, gx);
                end
            end
        end
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                checks++;
                if (o_iv[k] !== 1'b0 || o_dv[k] !== 1'b0 || o_ir[k] !== 32'h0 || o_dr[k] !== 32'h0) begin
                    errors++;
                    $display("FAIL reset_resp lat=%0d cyc=%0d got iv=%b dv=%b ir=%h dr=%h exp all 0",
                             k + 2, cyc, o_iv[k], o_dv[k], o_ir[k], o_dr[k]);
                end
                rq[k].delete();
            end else if (o_iv[k] || o_dv[k]) begin
                checks++;
                if (o_iv[k] && o_dv[k]) begin
                    errors++;
                    $display("FAIL both_rvalid lat=%0d cyc=%0d got iv=1 dv=1 exp one", k + 2, cyc);
                end else if (rq[k].size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_resp lat=%0d cyc=%0d got iv=%b dv=%b exp none",
                             k + 2, cyc, o_iv[k], o_dv[k]);
                end else begin
                    mre = rq[k].pop_front();
                    got_d = o_dv[k] ? o_dr[k] : o_ir[k];
                    if (mre.due != cyc || mre.src !== o_dv[k] || got_d !== mre.data ||
                        (o_dv[k] ? o_ir[k] : o_dr[k]) !== 32'h0) begin
                        errors++;
                        $display("FAIL resp lat=%0d got cyc=%0d src=%b data=%h exp cyc=%0d src=%b data=%h",
                                 k + 2, cyc, o_dv[k], got_d, mre.due, mre.src, mre.data);
                    end
                end
            end else begin
                checks++;
                if (o_ir[k] !== 32'h0 || o_dr[k] !== 32'h0) begin
                    errors++;
                    $display("FAIL idle_rdata lat=%0d cyc=%0d got ir=%h dr=%h exp 0",
                             k + 2, cyc, o_ir[k], o_dr[k]);
                end else if (rq[k].size() != 0 && rq[k][0].due <= cyc) begin
                    mre = rq[k].pop_front();
                    errors++;
                    $display("FAIL missing_resp lat=%0d cyc=%0d got none exp src=%b data=%h due=%0d",
                             k + 2, cyc, mre.src, mre.data, mre.due);
                end
            end
        end
        if (done && !fin) begin
            fin = 1'b1;
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (rq[k].size() != 0) begin
                    errors++;
                    $display("FAIL leftover_resp lat=%0d got %0d pending exp 0", k + 2, rq[k].size());
                end
            end
            checks++;
            if (gq.size() != 0) begin
                errors++;
                $display("FAIL leftover_grant got %0d pending exp 0", gq.size());
            end
        end
    end

    initial begin
        // Reset with both requesters asserting: no grants, outputs at reset values
        step(1, 1, 32'h0000_0100, 1, 1, 32'h0000_2000, 0, NONE, 0);
        step(1, 1, 32'h0000_0100, 1, 1, 32'h0000_2000, 0, NONE, 0);
        idle(1);

        // Single instruction fetch
        step(0, 1, 32'h0000_0100, 0, 1, 0, 0, GI, 32'h2402_0005);
        idle(3);

        // Data write: granted, no response
        step(0, 0, 0, 1, 0, 32'h0000_2000, 32'hDEAD_BEEF, GD, 0);
        idle(3);

        // Both held: D,D,D,D,I,D,D,D,D,I then the pending D drains
        step(0, 1, 32'h0000_0200, 1, 1, 32'h0000_3000, 0, GD, 32'h1111_3000);
        step(0, 1, 32'h0000_0200, 1, 1, 32'h0000_3004, 0, GD, 32'h1111_3004);
        step(0, 1, 32'h0000_0200, 1, 1, 32'h0000_3008, 0, GD, 32'h1111_3008);
        step(0, 1, 32'h0000_0200, 1, 1, 32'h0000_300C, 0, GD, 32'h1111_300C);
        step(0, 1, 32'h0000_0200, 1, 1, 32'h0000_3010, 0, GI, 32'h1111_0200);
        step(0, 1, 32'h0000_0204, 1, 1, 32'h0000_3010, 0, GD, 32'h1111_3010);
        step(0, 1, 32'h0000_0204, 1, 1, 32'h0000_3014, 0, GD, 32'h1111_3014);
        step(0, 1, 32'h0000_0204, 1, 1, 32'h0000_3018, 0, GD, 32'h1111_3018);
        step(0, 1, 32'h0000_0204, 1, 1, 32'h0000_301C, 0, GD, 32'h1111_301C);
        step(0, 1, 32'h0000_0204, 1, 1, 32'h0000_3020, 0, GI, 32'h1111_0204);
        step(0, 0, 0,             1, 1, 32'h0000_3020, 0, GD, 32'h1111_3020);
        idle(3);

        // Interleaved I read, D read, D write, I read on consecutive cycles
        step(0, 1, 32'h0000_0400, 0, 1, 0, 0, GI, 32'h1111_0400);
        step(0, 0, 0, 1, 1, 32'h0000_0500, 0, GD, 32'h1111_0500);
        step(0, 0, 0, 1, 0, 32'h0000_0600, 32'h1234_5678, GD, 0);
        step(0, 1, 32'h0000_0404, 0, 1, 0, 0, GI, 32'h1111_0404);
        idle(4);

        // D read then reset before its data returns: response must be dropped
        step(0, 0, 0, 1, 1, 32'h0000_0700, 0, GD, 32'h1111_0700);
        step(1, 0, 0, 0, 1, 0, 0, NONE, 0);
        step(0, 1, 32'h0000_0100, 0, 1, 0, 0, GI, 32'h2402_0005);
        idle(4);

        done = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port, fixed-latency unified memory between the core's instruction-fetch requester (I) and data-access requester (D).
- Sits between the pipelined MIPS core and the memory model.
- Grants at most one request per cycle and tags each granted read so its response returns to the correct requester.
- Gives D priority, with a streak limit that bounds I starvation.

Parameters:
MEM_LATENCY, 1, cycles from a granted read (mem_en=1, mem_rd_wr=1) to valid mem_rdata; legal range 1..8.
MAX_DATA_STREAK, 4, maximum consecutive D grants while I is pending before I is forced through; legal range 1..15.

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
i_req  in  1  instruction read request; held with i_addr stable until i_gnt
i_addr  in  32  instruction address
i_gnt  out  1  I request accepted this cycle
i_rvalid  out  1  i_rdata valid this cycle
i_rdata  out  32  instruction read data
d_req  in  1  data request; held with all d_* inputs stable until d_gnt
d_rd_wr  in  1  1 = read, 0 = write
d_addr  in  32  data address
d_wdata  in  32  write data
d_gnt  out  1  D request accepted this cycle
d_rvalid  out  1  d_rdata valid this cycle (reads only)
d_rdata  out  32  data read data
mem_en  out  1  memory access this cycle
mem_rd_wr  out  1  1 = read, 0 = write
mem_addr  out  32  memory address
mem_wdata  out  32  memory write data
mem_rdata  in  32  memory read data, valid MEM_LATENCY cycles after the read issue

Behaviour:
- Single clock (clk). Reset is synchronous, active-high.
- Reset values: i_gnt=0, d_gnt=0, i_rvalid=0, d_rvalid=0, i_rdata=0, d_rdata=0, mem_en=0, mem_rd_wr=1, mem_addr=0, mem_wdata=0, FSM=NORMAL, streak=0, tag pipeline cleared.
- Grants are combinational from the req inputs and registered state. The winner's signals drive mem_* in the same cycle.
- With no grant: mem_en=0, mem_rd_wr=1, mem_addr=0, mem_wdata=0.
- An I grant always issues mem_rd_wr=1; mem_wdata=0.
- A D grant issues mem_rd_wr=d_rd_wr, mem_addr=d_addr, mem_wdata=d_wdata.
- FSM states:
  - NORMAL: if d_req, grant D; else if i_req, grant I.
  - FORCE_I: if i_req, grant I; else if d_req, grant D.
- streak counter (4-bit):
  - Increments on each D grant while i_req=1.
  - Clears on any I grant, or on any cycle with i_req=0.
- Transitions:
  - NORMAL -> FORCE_I when a D grant makes streak reach MAX_DATA_STREAK while i_req=1.
  - FORCE_I -> NORMAL on an I grant, or when i_req=0.
- Tag pipeline: MEM_LATENCY stages, each holding {valid, src}.
  - Stage 0 loads valid=1 on any granted read, with src=0 for I and src=1 for D.
  - D writes load valid=0.
- Response routing at pipeline output:
  - valid with src=0: i_rvalid=1, i_rdata=mem_rdata.
  - valid with src=1: d_rvalid=1, d_rdata=mem_rdata.
  - rdata outputs are 0 whenever the matching rvalid=0.
- Read latency is exactly MEM_LATENCY cycles from grant to rvalid. Back-to-back reads sustain one response per cycle, delivered in grant order.
- Writes complete at grant and produce no rvalid.
- Simultaneous requests: exactly one grant per cycle; the loser's request stays pending with no change.
- A response emerging in the same cycle as a new grant is legal; both proceed.
- Reset mid-operation: all in-flight tags are dropped. No rvalid is asserted in any cycle after reset is sampled high. The FSM returns to NORMAL.
- Addresses pass through unmodified; alignment is the requester's responsibility.

Test Plan:
1. Assert reset for 2 cycles with both reqs high -> every output equals its reset value; mem_rd_wr=1; no grants during reset.
2. MEM_LATENCY=2; i_req=1, i_addr=0x0000_0100 in cycle T; memory returns 0x2402_0005 -> i_gnt=1, mem_en=1, mem_addr=0x100 at T; i_rvalid=1, i_rdata=0x2402_0005 at T+2; d_rvalid stays 0.
3. d_req=1, d_rd_wr=0, d_addr=0x0000_2000, d_wdata=0xDEAD_BEEF -> d_gnt=1, mem_en=1, mem_rd_wr=0, mem_addr=0x2000, mem_wdata=0xDEAD_BEEF same cycle; no d_rvalid in any later cycle.
4. MAX_DATA_STREAK=4; i_req and d_req (reads) held continuously for 10 cycles -> grant sequence D,D,D,D,I,D,D,D,D,I; responses route to the correct requester in grant order.
5. MEM_LATENCY=3; interleaved I read, D read, D write, I read on consecutive cycles -> i_rvalid at +3, d_rvalid at +4, nothing at +5, i_rvalid at +6, each carrying that cycle's mem_rdata.
6. MEM_LATENCY=2; D read granted at T, reset=1 at T+1 -> d_rvalid=0 at T+2 and later; first grant after reset deassertion behaves as in scenario 2.
